// File: rtl/heightmap_pixel_writer_pkg.sv
// Shared constants for the heightmap pixel writer: terrain palette, height
// thresholds, write-FSM encoding and the framebuffer address width.
package heightmap_pixel_writer_pkg;

   localparam int VGA_AW = 19;

   localparam logic [7:0] RGB_WATER     = 8'h03;
   localparam logic [7:0] RGB_GRASS     = 8'h1C;
   localparam logic [7:0] RGB_ROCK      = 8'h8C;
   localparam logic [7:0] RGB_HIGH_ROCK = 8'h92;
   localparam logic [7:0] RGB_SNOW      = 8'hFF;

   // Lower bound (inclusive) of each band above water
   localparam logic [7:0] Z_GRASS     = 8'd64;
   localparam logic [7:0] Z_ROCK      = 8'd112;
   localparam logic [7:0] Z_HIGH_ROCK = 8'd176;
   localparam logic [7:0] Z_SNOW      = 8'd224;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2
   } wr_state_t;

   function automatic logic [7:0] z_to_rgb(input logic [7:0] z);
      logic [7:0] rgb;
      if (z < Z_GRASS)          rgb = RGB_WATER;
      else if (z < Z_ROCK)      rgb = RGB_GRASS;
      else if (z < Z_HIGH_ROCK) rgb = RGB_ROCK;
      else if (z < Z_SNOW)      rgb = RGB_HIGH_ROCK;
      else                      rgb = RGB_SNOW;
      return rgb;
   endfunction

endpackage

// File: rtl/heightmap_pixel_writer_fifo.sv
// Synchronous FIFO with registered read; occupancy, full and empty come from
// read/write pointers that carry one extra wrap bit.
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 28
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_reg;
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Storage and read register stay unreset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      if (pop_ok)
         rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   assign rd_data = rd_data_reg;
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/heightmap_pixel_writer.sv
// Draws buffered (x, y, z) height samples into the VGA framebuffer as square
// pixel blocks coloured by height, and flags completion of each dim*dim frame.
module heightmap_pixel_writer
   import heightmap_pixel_writer_pkg::*;
#(
   parameter int SCALE_LOG2 = 1,
   parameter int H_RES      = 640,
   parameter int X_OFF      = 0,
   parameter int Y_OFF      = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        dim_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic [7:0]        pix_z,
   output logic [VGA_AW-1:0] vga_addr,
   output logic [7:0]        vga_data,
   output logic              vga_write,
   input  logic              vga_waitrequest,
   output logic              frame_done,
   output logic              busy
);

   localparam int FIFO_W = 28;
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;
   localparam logic [SCALE_LOG2-1:0] SUB_ONE = 1;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] fifo_rd_data;
   logic [CW-1:0]     fifo_count;

   wr_state_t         state_reg;
   wr_state_t         state_next;

   logic [9:0]            x_reg;
   logic [9:0]            y_reg;
   logic [7:0]            colour_reg;
   logic [SCALE_LOG2-1:0] sx_reg;
   logic [SCALE_LOG2-1:0] sy_reg;
   logic [8:0]            dim_r;
   logic [17:0]           sample_cnt_reg;
   logic [17:0]           sample_cnt_inc;
   logic [17:0]           dim_sq;
   logic                  frame_done_reg;
   logic                  sub_last;
   logic                  last_accept;
   logic [19:0]           px;
   logic [19:0]           py;
   logic [VGA_AW-1:0]     addr_trunc;

   // Ready is forced low while reset is held, independent of pointer state
   assign pix_ready = !fifo_full && !reset;
   assign fifo_push = pix_valid && pix_ready;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .wr_data ({pix_x, pix_y, pix_z}),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign sub_last       = (sx_reg == SUB_MAX) && (sy_reg == SUB_MAX);
   assign sample_cnt_inc = sample_cnt_reg + 18'd1;
   assign dim_sq         = 18'(dim_r) * 18'(dim_r);

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      fifo_pop    = 1'b0;
      last_accept = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: state_next = ST_WRITE;
         ST_WRITE: begin
            if (!vga_waitrequest && sub_last) begin
               last_accept = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = ST_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg          <= '0;
         y_reg          <= '0;
         colour_reg     <= '0;
         sx_reg         <= '0;
         sy_reg         <= '0;
         sample_cnt_reg <= '0;
         frame_done_reg <= 1'b0;
         dim_r          <= dim_in;
      end else begin
         frame_done_reg <= 1'b0;
         if (state_reg == ST_LOAD) begin
            x_reg      <= fifo_rd_data[27:18];
            y_reg      <= fifo_rd_data[17:8];
            colour_reg <= z_to_rgb(fifo_rd_data[7:0]);
            sx_reg     <= '0;
            sy_reg     <= '0;
         end else if (state_reg == ST_WRITE && !vga_waitrequest) begin
            // sx/sy are exactly SCALE_LOG2 wide, so both wrap on their own
            sx_reg <= sx_reg + SUB_ONE;
            if (sx_reg == SUB_MAX)
               sy_reg <= sy_reg + SUB_ONE;
            if (last_accept) begin
               if (sample_cnt_inc == dim_sq) begin
                  sample_cnt_reg <= '0;
                  frame_done_reg <= 1'b1;
               end else begin
                  sample_cnt_reg <= sample_cnt_inc;
               end
            end
         end
      end
   end

   assign px         = 20'(X_OFF) + (20'(x_reg) << SCALE_LOG2) + 20'(sx_reg);
   assign py         = 20'(Y_OFF) + (20'(y_reg) << SCALE_LOG2) + 20'(sy_reg);
   assign addr_trunc = VGA_AW'(py * 20'(H_RES) + px);

   assign vga_write  = (state_reg == ST_WRITE);
   assign vga_addr   = vga_write ? addr_trunc : '0;
   assign vga_data   = vga_write ? colour_reg : '0;
   assign frame_done = frame_done_reg;
   assign busy       = (fifo_count != '0) || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_heightmap_pixel_writer.sv
// Scoreboard bench for heightmap_pixel_writer: stimulus queues the expected
// framebuffer writes, a negedge monitor pops and checks each accepted write.
module tb_heightmap_pixel_writer;

   localparam int XO = 100;
   localparam int YO = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  dim_in = 9'd20;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic [7:0]  pix_z = '0;
   logic [18:0] vga_addr;
   logic [7:0]  vga_data;
   logic        vga_write;
   logic        vga_waitrequest = 1'b0;
   logic        frame_done;
   logic        busy;

   heightmap_pixel_writer #(
      .SCALE_LOG2 (1),
      .H_RES      (640),
      .X_OFF      (XO),
      .Y_OFF      (YO),
      .FIFO_DEPTH (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .dim_in          (dim_in),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_x           (pix_x),
      .pix_y           (pix_y),
      .pix_z           (pix_z),
      .vga_addr        (vga_addr),
      .vga_data        (vga_data),
      .vga_write       (vga_write),
      .vga_waitrequest (vga_waitrequest),
      .frame_done      (frame_done),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          acc36_cyc = -1;
   int          fd_count = 0;
   int          fd_cyc = -1;
   int          t_push = 0;
   bit          saw_not_ready = 0;
   bit          hold_valid = 0;
   logic [18:0] hold_addr;
   logic [7:0]  hold_data;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write accepted by the slave must match the queue head
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
         hold_valid = 0;
      end else begin
         if (vga_write && hold_valid) begin
            n_cmp++;
            if (vga_addr !== hold_addr || vga_data !== hold_data) begin
               n_err++;
               $display("FAIL stall_hold: got addr=%0d data=%h required addr=%0d data=%h",
                        vga_addr, vga_data, hold_addr, hold_data);
            end
         end
         if (vga_write && !vga_waitrequest) begin
            acc_cnt++;
            if (acc_cnt == 36) acc36_cyc = cyc;
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr=%0d data=%h required no write",
                        vga_addr, vga_data);
            end else begin
               e = sb_q.pop_front();
               if (vga_addr !== e.addr || vga_data !== e.data) begin
                  n_err++;
                  $display("FAIL write: got addr=%0d data=%h required addr=%0d data=%h",
                           vga_addr, vga_data, e.addr, e.data);
               end else begin
                  $display("cyc %0d write addr=%0d data=%h ok", cyc, vga_addr, vga_data);
               end
            end
         end
         hold_valid = vga_write && vga_waitrequest;
         hold_addr  = vga_addr;
         hold_data  = vga_data;
         if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
         end
         if (!pix_ready) saw_not_ready = 1;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Hand formula for a 2x2 block at offset (XO, YO) on a 640-wide screen
   function automatic logic [18:0] exp_addr(input int x, input int y, input int sx, input int sy);
      int a;
      a = (YO + 2 * y + sy) * 640 + XO + 2 * x + sx;
      return 19'(a);
   endfunction

   task automatic push(input int x, input int y, input logic [7:0] z, input logic [7:0] d);
      int b = 0;
      pix_x = 10'(x);
      pix_y = 10'(y);
      pix_z = z;
      pix_valid = 1'b1;
      do begin
         @(negedge clk);
         b++;
      end while (!pix_ready && b < 200);
      if (!pix_ready) chk("push_timeout", 0, 1);
      t_push = cyc;
      for (int sy = 0; sy < 2; sy++)
         for (int sx = 0; sx < 2; sx++)
            sb_q.push_back('{exp_addr(x, y, sx, sy), d});
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int b = 0;
      do begin
         @(negedge clk);
         b++;
      end while ((busy || sb_q.size() != 0) && b < 1000);
      chk("drain", int'(busy || sb_q.size() != 0), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_write(output int wcyc);
      int b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (!vga_write && b < 100);
      chk("write_seen", int'(vga_write), 1);
      wcyc = cyc;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      acc_cnt = 0;
      acc36_cyc = -1;
      fd_count = 0;
      fd_cyc = -1;
      @(negedge clk);
      chk("ready_in_reset", int'(pix_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(pix_ready), 1);
      chk("rst_write", int'(vga_write), 0);
      chk("rst_addr", int'(vga_addr), 0);
      chk("rst_data", int'(vga_data), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_busy", int'(busy), 0);
   endtask

   int t5x[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
   int t5y[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
   logic [7:0] t5z[9] = '{8'd176, 8'd223, 8'd224, 8'd255, 8'd50, 8'd100, 8'd150, 8'd200, 8'd250};
   logic [7:0] t5d[9] = '{8'h92, 8'h92, 8'hFF, 8'hFF, 8'h03, 8'h1C, 8'h8C, 8'h92, 8'hFF};
   int t4x[6] = '{1, 2, 5, 9, 0, 319};
   int t4y[6] = '{1, 1, 7, 0, 9, 200};
   logic [7:0] t4z[6] = '{8'd0, 8'd63, 8'd64, 8'd111, 8'd112, 8'd175};
   logic [7:0] t4d[6] = '{8'h03, 8'h03, 8'h1C, 8'h1C, 8'h8C, 8'h8C};

   initial begin
      int w;
      int base;
      @(posedge clk); #1;
      apply_reset();
      @(posedge clk); #1;

      // 1: single sample, latency and block layout
      push(0, 0, 8'd10, 8'h03);
      pix_valid = 1'b0;
      wait_write(w);
      chk("t1_latency", w, t_push + 3);
      chk("t1_first_addr", int'(vga_addr), 32100);
      repeat (4) @(negedge clk);
      chk("t1_busy_drop", int'(busy), 0);
      wait_idle();
      chk("t1_writes", acc_cnt, 4);

      // 2: offset arithmetic
      @(posedge clk); #1;
      push(3, 2, 8'd200, 8'h92);
      pix_valid = 1'b0;
      wait_write(w);
      chk("t2_first_addr", int'(vga_addr), 34666);
      wait_idle();
      chk("t2_writes", acc_cnt, 8);

      // 3: five-cycle stall on the second sub-pixel
      @(posedge clk); #1;
      push(4, 3, 8'd130, 8'h8C);
      pix_valid = 1'b0;
      wait_write(w);
      @(posedge clk); #1;
      vga_waitrequest = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vga_waitrequest = 1'b0;
      wait_idle();
      chk("t3_writes", acc_cnt, 12);

      // 4: back-to-back stream fills the FIFO
      @(posedge clk); #1;
      saw_not_ready = 0;
      for (int i = 0; i < 6; i++) push(t4x[i], t4y[i], t4z[i], t4d[i]);
      pix_valid = 1'b0;
      wait_idle();
      chk("t4_backpressure", int'(saw_not_ready), 1);
      chk("t4_writes", acc_cnt, 36);
      chk("no_early_frame_done", fd_count, 0);

      // 5: dim=3 frame of nine samples, then a tenth
      @(posedge clk); #1;
      dim_in = 9'd3;
      apply_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 9; i++) push(t5x[i], t5y[i], t5z[i], t5d[i]);
      pix_valid = 1'b0;
      wait_idle();
      chk("t5_writes", acc_cnt, 36);
      chk("t5_frame_done_count", fd_count, 1);
      chk("t5_frame_done_cycle", fd_cyc, acc36_cyc + 1);
      @(posedge clk); #1;
      push(1, 1, 8'd70, 8'h1C);
      pix_valid = 1'b0;
      wait_idle();
      chk("t5_tenth_no_pulse", fd_count, 1);

      // 6: reset on the third sub-pixel with two samples queued
      @(posedge clk); #1;
      push(6, 6, 8'd230, 8'hFF);
      push(7, 6, 8'd20, 8'h03);
      push(8, 6, 8'd80, 8'h1C);
      pix_valid = 1'b0;
      wait_write(w);
      @(posedge clk); #1;
      @(posedge clk); #1;
      apply_reset();
      repeat (10) @(negedge clk);
      chk("t6_no_writes_after_reset", acc_cnt, 0);
      chk("t6_busy_after_reset", int'(busy), 0);
      @(posedge clk); #1;
      push(2, 5, 8'd120, 8'h8C);
      pix_valid = 1'b0;
      wait_idle();
      chk("t6_fresh_writes", acc_cnt, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
